// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: counter encodings and table entry layout.
package branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Tag field sized for the smallest legal table (4 entries); larger tables zero-extend.
  localparam int MAX_TAG_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function (SNT <-> WNT <-> WT <-> ST).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       taken,
  output logic [1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken) begin
      if (ctr_in != CTR_ST) ctr_out = ctr_in + 2'd1;
    end else begin
      if (ctr_in != CTR_SNT) ctr_out = ctr_in - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter branch predictor, zero-cycle lookup, update at clk edge.
// Optional gshare counter indexing enabled by defining BRANCH_PRED_GSHARE_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  bp_entry_t        tbl [ENTRIES];
  logic [IDX_W-1:0] fidx, uidx, fcidx, ucidx;
  logic [TAG_W-1:0] ftag, utag;
  logic             fhit, uhit;
  logic [1:0]       ctr_nxt;

  assign fidx = IDX_W'(fetch_pc >> 2);
  assign uidx = IDX_W'(upd_pc >> 2);
  assign ftag = TAG_W'(fetch_pc >> (IDX_W + 2));
  assign utag = TAG_W'(upd_pc >> (IDX_W + 2));

`ifdef BRANCH_PRED_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  assign fcidx = fidx ^ ghr;
  assign ucidx = uidx ^ ghr;

  always_ff @(posedge clk) begin
    if (rst)            ghr <= '0;
    else if (upd_valid) ghr <= {ghr[IDX_W-2:0], upd_taken};
  end
`else
  assign fcidx = fidx;
  assign ucidx = uidx;
`endif

  assign fhit = tbl[fidx].valid && (tbl[fidx].tag == MAX_TAG_W'(ftag));
  assign uhit = tbl[uidx].valid && (tbl[uidx].tag == MAX_TAG_W'(utag));

  // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
  assign pred_taken  = !rst && fhit && tbl[fcidx].ctr[1];
  assign pred_target = pred_taken ? tbl[fidx].target : fetch_pc + 32'd4;

  sat_counter2 u_ctr (
    .ctr_in  (tbl[ucidx].ctr),
    .taken   (upd_taken),
    .ctr_out (ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].ctr   <= CTR_RESET;
      end
    end else if (upd_valid) begin
      if (uhit) begin
        tbl[ucidx].ctr <= ctr_nxt;
        if (upd_taken) tbl[uidx].target <= upd_target;
      end else if (upd_taken) begin
        // Allocation evicts whatever lived at this index.
        tbl[uidx].valid  <= 1'b1;
        tbl[uidx].tag    <= MAX_TAG_W'(utag);
        tbl[uidx].target <= upd_target;
        tbl[ucidx].ctr   <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan then randomized traffic vs a behavioural model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          id;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Behavioural model: per-slot arrays, counters held as integers 0..3.
  bit          m_valid [ENTRIES];
  longint      m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_ghr;

  function automatic int bslot(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % ENTRIES);
  endfunction

  function automatic int cslot(input logic [31:0] pc);
`ifdef BRANCH_PRED_GSHARE_EN
    return bslot(pc) ^ m_ghr;
`else
    return bslot(pc);
`endif
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[bslot(pc)] && (m_tag[bslot(pc)] == longint'(pc) / (4 * ENTRIES));
  endfunction

  task automatic m_update(input logic r, input logic uv, input logic [31:0] upc,
                          input logic ut, input logic [31:0] utgt);
    int b, c;
    b = bslot(upc);
    c = cslot(upc);
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_ghr = 0;
    end else if (uv) begin
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[c] = (m_ctr[c] < 3) ? m_ctr[c] + 1 : 3;
          m_tgt[b] = utgt;
        end else begin
          m_ctr[c] = (m_ctr[c] > 0) ? m_ctr[c] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[b] = 1'b1;
        m_tag[b]   = longint'(upc) / (4 * ENTRIES);
        m_tgt[b]   = utgt;
        m_ctr[c]   = 2;
      end
      m_ghr = ((m_ghr * 2) + int'(ut)) % ENTRIES;
    end
  endtask

  // One cycle: drive inputs, push the expected prediction, advance the model.
  // chk=1 supplies hand-derived constants (used only with plain indexing).
  task automatic step(input string nm, input int id, input logic r, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic chk, input logic et,
                      input logic [31:0] etgt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    e.name   = nm;
    e.id     = id;
    e.taken  = !r && m_hit(fpc) && (m_ctr[cslot(fpc)] >= 2);
    e.target = e.taken ? m_tgt[bslot(fpc)] : fpc + 32'd4;
`ifndef BRANCH_PRED_GSHARE_EN
    if (chk) begin
      e.taken  = et;
      e.target = etgt;
    end
`endif
    q.push_back(e);
    m_update(r, uv, upc, ut, utgt);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (pred_taken !== e.taken) begin
        n_fail++;
        $display("FAIL %s#%0d pred_taken fetch_pc=%h got %0b exp %0b", e.name, e.id, fetch_pc, pred_taken, e.taken);
      end
      n_chk++;
      if (pred_target !== e.target) begin
        n_fail++;
        $display("FAIL %s#%0d pred_target fetch_pc=%h got %h exp %h", e.name, e.id, fetch_pc, pred_target, e.target);
      end
    end
  end

  logic [31:0] pool [8];

  initial begin
    int d = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_ghr = 0;

    // Reset and first allocation
    step("reset",   d++, 1, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104);
    step("postrst", d++, 0, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104);
    step("alloc",   d++, 0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 0, 32'h104);
    step("hit",     d++, 0, 32'h100, 0, 0, 0, 0, 1, 1, 32'h80);
    // Counter walk: 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00
    step("ctr_t1",  d++, 0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 1, 32'h80);
    step("ctr_t2",  d++, 0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 1, 32'h80);
    step("ctr_n1",  d++, 0, 32'h100, 1, 32'h100, 0, 32'h0,  1, 1, 32'h80);
    step("ctr_n2",  d++, 0, 32'h100, 1, 32'h100, 0, 32'h0,  1, 1, 32'h80);
    step("ctr_n3",  d++, 0, 32'h100, 1, 32'h100, 0, 32'h0,  1, 0, 32'h104);
    step("ctr_n4",  d++, 0, 32'h100, 1, 32'h100, 0, 32'h0,  1, 0, 32'h104);
    step("ctr_sat", d++, 0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 0, 32'h104);
    step("ctr_up",  d++, 0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 0, 32'h104);
    step("retrain", d++, 0, 32'h100, 0, 0, 0, 0, 1, 1, 32'h80);
    // Alias: 0x100 + 4*ENTRIES shares the index, different tag
    step("alias_w", d++, 0, 32'h100, 1, 32'h100 + 4 * ENTRIES, 1, 32'h200, 1, 1, 32'h80);
    step("alias_o", d++, 0, 32'h100, 0, 0, 0, 0, 1, 0, 32'h104);
    step("alias_n", d++, 0, 32'h100 + 4 * ENTRIES, 0, 0, 0, 0, 1, 1, 32'h200);
    // Same-cycle hazard and wrap
    step("haz_0",   d++, 0, 32'h40, 1, 32'h40, 1, 32'h300, 1, 0, 32'h44);
    step("haz_1",   d++, 0, 32'h40, 0, 0, 0, 0, 1, 1, 32'h300);
    step("wrap",    d++, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0, 32'h0);
    // Not-taken miss does not allocate
    step("nt_miss", d++, 0, 32'h80, 1, 32'h80, 0, 32'h500, 1, 0, 32'h84);
    step("nt_chk",  d++, 0, 32'h80, 0, 0, 0, 0, 1, 0, 32'h84);
    // Reset mid-training discards state, with a competing update
    step("rst_mid", d++, 1, 32'h200, 1, 32'h200, 1, 32'h600, 1, 0, 32'h204);
    step("rst_a",   d++, 0, 32'h200, 0, 0, 0, 0, 1, 0, 32'h204);
    step("rst_b",   d++, 0, 32'h40, 0, 0, 0, 0, 1, 0, 32'h44);
    // History T,N,T on another PC, then 0x100 trained and probed
    step("hist_t",  d++, 0, 32'h100, 1, 32'h20, 1, 32'h700, 0, 0, 0);
    step("hist_n",  d++, 0, 32'h100, 1, 32'h20, 0, 32'h0,   0, 0, 0);
    step("hist_t2", d++, 0, 32'h100, 1, 32'h20, 1, 32'h700, 0, 0, 0);
    step("hist_a",  d++, 0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 0);
    step("hist_p",  d++, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    step("hist_q",  d++, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);

    pool[0] = 32'h100; pool[1] = 32'h100 + 4 * ENTRIES; pool[2] = 32'h40;
    pool[3] = 32'hFFFF_FFFC; pool[4] = 32'h104; pool[5] = 32'h20;
    pool[6] = 32'h8000_0100; pool[7] = 32'h44;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] fpc, upc, tgt;
      logic uv, ut, r;
      fpc = ($urandom_range(3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(7)];
      upc = ($urandom_range(7) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(7)];
      tgt = $urandom() & 32'hFFFF_FFFC;
      uv  = ($urandom_range(1) == 1);
      ut  = ($urandom_range(9) < 6);
      r   = ($urandom_range(199) == 0);
      step("rnd", n, r, fpc, uv, upc, ut, tgt, 0, 0, 0);
    end

    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
